// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction sequencer: IDLE -> FETCH (imem req/ack) -> EXEC (wait exec_done) -> next PC.
// Optional macro PC_ALIGN_CHECK_EN: refuse misaligned next-PC targets and halt with misalign_err.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          IMEM_TIMEOUT = 15,
    parameter int          CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        resetl,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    input  logic [63:0] SignExtImm64,
    input  logic        halt_req,
    output logic [63:0] CurrentPC,
    output logic [1:0]  state_o,
    output logic        timeout_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IMEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmo_q, tmo_d;
    logic             mis_q, mis_d;
    logic             taken;
    logic [63:0]      next_pc;
    logic             misalign_hit;

    assign taken   = (Branch & ALUZero) | Uncondbranch;
    assign next_pc = pc_q + (taken ? SignExtImm64 : 64'd4);
    assign cnt_inc = cnt_q + 1'b1;

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_hit = |next_pc[1:0];
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = halt_req ? S_HALT : S_FETCH;
            end
            S_FETCH: begin
                // An ack arriving on the limit cycle still completes the fetch.
                if (imem_ack) begin
                    instr_d = imem_data;
                    vld_d   = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LIMIT) begin
                        tmo_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    cnt_d = '0;
                    if (misalign_hit) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = halt_req ? S_HALT : S_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = vld_q;
    assign instr_out   = instr_q;
    assign CurrentPC   = pc_q;
    assign state_o     = state_q;
    assign timeout_err = tmo_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: fetches push expected instructions, a negedge monitor checks instr_valid pulses.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        exec_done = 1'b0;
    logic        Branch = 1'b0;
    logic        ALUZero = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic [63:0] SignExtImm64 = '0;
    logic        halt_req = 1'b0;
    logic [63:0] CurrentPC;
    logic [1:0]  state_o;
    logic        timeout_err;
    logic        misalign_err;

    pc_fetch_sequencer #(.RESET_PC(64'h100), .IMEM_TIMEOUT(15), .CNT_W(4)) dut (
        .CLK(CLK), .resetl(resetl),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_out(instr_out),
        .exec_done(exec_done), .Branch(Branch), .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
        .SignExtImm64(SignExtImm64), .halt_req(halt_req),
        .CurrentPC(CurrentPC), .state_o(state_o),
        .timeout_err(timeout_err), .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every instr_valid pulse must match the oldest expected fetch and last one cycle.
    logic vld_prev = 1'b0;
    always @(negedge CLK) begin
        if (instr_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_instr_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("instr_out", {32'd0, instr_out}, {32'd0, e.instr});
                chk("pc_at_valid", CurrentPC, e.pc);
            end
            if (vld_prev) chk("instr_valid_pulse_width", 64'd2, 64'd1);
        end
        vld_prev = instr_valid;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        imem_ack = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
        Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0;
        tick(); tick();
        resetl = 1'b1;
    endtask

    task automatic wait_req(input logic [63:0] exp_addr);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) chk("imem_req_timeout", 64'd0, 64'd1);
        chk("imem_addr", imem_addr, exp_addr);
    endtask

    // Fetch with wait_cycles idle cycles before ack; optional stray exec_done/halt_req during the wait.
    task automatic fetch(input logic [31:0] data, input int wait_cycles, input logic [63:0] exp_addr,
                         input bit stray);
        exp_t e;
        wait_req(exp_addr);
        for (int i = 0; i < wait_cycles; i++) begin
            exec_done = stray; halt_req = stray;
            tick();
        end
        exec_done = 1'b0; halt_req = 1'b0;
        imem_ack = 1'b1; imem_data = data;
        e.instr = data; e.pc = exp_addr;
        sb.push_back(e);
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic exec(input logic br, input logic z, input logic ub, input logic [63:0] imm,
                        input logic hlt, input logic [63:0] exp_pc, input logic [1:0] exp_state);
        exec_done = 1'b1; Branch = br; ALUZero = z; Uncondbranch = ub; SignExtImm64 = imm;
        halt_req = hlt;
        tick();
        exec_done = 1'b0; Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0; halt_req = 1'b0;
        chk("pc_after_exec", CurrentPC, exp_pc);
        chk("state_after_exec", {62'd0, state_o}, {62'd0, exp_state});
    endtask

    initial begin
        int n;
        // Reset state
        do_reset();
        chk("rst_pc", CurrentPC, 64'h100);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr_out", {32'd0, instr_out}, 64'd0);
        chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        chk("rst_misalign_err", {63'd0, misalign_err}, 64'd0);

        // Basic fetch/exec, stray exec_done/halt_req during FETCH ignored
        fetch(32'h8B020020, 2, 64'h100, 1'b1);
        exec(0, 0, 0, 64'h0, 0, 64'h104, 2'b01);
        // Conditional branch taken / not taken
        fetch(32'h11111111, 0, 64'h104, 1'b0);
        exec(1, 1, 0, 64'h40, 0, 64'h144, 2'b01);
        fetch(32'h22222222, 0, 64'h144, 1'b0);
        exec(1, 0, 0, 64'h40, 0, 64'h148, 2'b01);
        // Back to 0, then wrap below zero
        fetch(32'h33333333, 1, 64'h148, 1'b0);
        exec(0, 0, 1, 64'hFFFF_FFFF_FFFF_FEB8, 0, 64'h0, 2'b01);
        fetch(32'h44444444, 0, 64'h0, 1'b0);
        exec(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2'b01);

        // Fetch timeout after exactly 15 FETCH cycles
        wait_req(64'hFFFF_FFFF_FFFF_FFF8);
        n = 0;
        for (int i = 0; i < 40 && imem_req; i++) begin
            n++;
            tick();
        end
        chk("timeout_fetch_cycles", 64'(n), 64'd15);
        chk("timeout_state", {62'd0, state_o}, 64'd3);
        chk("timeout_err", {63'd0, timeout_err}, 64'd1);
        chk("timeout_req", {63'd0, imem_req}, 64'd0);
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF; exec_done = 1'b1; Uncondbranch = 1'b1;
        tick(); tick();
        imem_ack = 1'b0; exec_done = 1'b0; Uncondbranch = 1'b0;
        tick();
        chk("halt_pc_hold", CurrentPC, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("halt_state_hold", {62'd0, state_o}, 64'd3);

        // Ack on the limit cycle wins over timeout
        do_reset();
        fetch(32'h55555555, 14, 64'h100, 1'b0);
        chk("limit_ack_state", {62'd0, state_o}, 64'd2);
        chk("limit_ack_no_timeout", {63'd0, timeout_err}, 64'd0);
        exec(0, 0, 0, 64'h0, 0, 64'h104, 2'b01);

        // exec_done with halt_req: PC advances, then HALT with no further requests
        do_reset();
        fetch(32'h66666666, 0, 64'h100, 1'b0);
        exec(0, 0, 1, 64'h100, 0, 64'h200, 2'b01);
        fetch(32'h77777777, 0, 64'h200, 1'b0);
        exec(0, 0, 0, 64'h0, 1, 64'h204, 2'b11);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) n++;
            tick();
        end
        chk("halt_no_req", 64'(n), 64'd0);

        // Reset in the middle of EXEC
        do_reset();
        fetch(32'h88888888, 0, 64'h100, 1'b0);
        exec(0, 0, 0, 64'h0, 0, 64'h104, 2'b01);
        fetch(32'h99999999, 0, 64'h104, 1'b0);
        tick();
        resetl = 1'b0;
        tick();
        chk("midexec_rst_pc", CurrentPC, 64'h100);
        chk("midexec_rst_state", {62'd0, state_o}, 64'd0);
        chk("midexec_rst_valid", {63'd0, instr_valid}, 64'd0);
        resetl = 1'b1;

        // Misaligned target
        fetch(32'hAAAAAAAA, 0, 64'h100, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        exec(0, 0, 1, 64'h2, 0, 64'h100, 2'b11);
        chk("misalign_err", {63'd0, misalign_err}, 64'd1);
`else
        exec(0, 0, 1, 64'h2, 0, 64'h102, 2'b01);
        chk("misalign_err", {63'd0, misalign_err}, 64'd0);
`endif
        tick(); tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
